// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port word store with valid/ready request and response channels,
// byte-lane write masks and a self-clearing sweep after reset. Optional build macro: DMEM_WRITE_ACK_EN.
module data_memory_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 9,
  parameter  int DEPTH      = 512,
  localparam int LANES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]      req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef DMEM_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $error("data_memory_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
      $error("data_memory_ctrl: DEPTH must lie in 1 .. 2**ADDR_WIDTH");
    end
  endgenerate

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  rsp_load;
  logic [IDX_W-1:0]      addr_idx;
  logic [IDX_W-1:0]      init_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;

  assign init_busy = (state == ST_INIT);
  assign req_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign addr_idx  = req_addr[IDX_W-1:0];
  assign init_idx  = init_cnt[IDX_W-1:0];

  // rd_word doubles as read data and as the pre-write value for ack responses.
  always_comb begin
    in_range = ({1'b0, req_addr} < DEPTH_LIM);
    rd_word  = in_range ? mem[addr_idx] : '0;
    wr_word  = rd_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (req_wmask[i]) begin
        wr_word[8*i +: 8] = req_wdata[8*i +: 8];
      end
    end
    rsp_load = accept && (!req_write || WRITE_ACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == LAST_IDX) begin
        state    <= ST_RUN;
        init_cnt <= '0;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_idx] <= '0;
    end else if (accept && req_write && in_range) begin
      mem[addr_idx] <= wr_word;
    end
  end

  // Loading a new response takes priority over draining the old one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (rsp_load) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= rd_word;
      rsp_err   <= !in_range;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)));

  a_no_req_in_init: assert property (@(posedge clk) disable iff (!reset_n)
    init_busy |-> !req_ready);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed checks on a default instance and a DEPTH=300 instance sharing stimulus.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_write, rsp_ready;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_wmask;

  logic        req_ready, rsp_valid, rsp_err, init_busy;
  logic [15:0] rsp_rdata;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, init_busy_b;
  logic [15:0] rsp_rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_ctrl u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_busy(init_busy)
  );

  data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .DEPTH(300)) u_dut300 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .init_busy(init_busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [8:0] a, input logic [15:0] d, input logic [1:0] m);
    int unsigned n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] e, input logic [15:0] e_b, input logic err_b);
    issue(1'b0, a, 16'hDEAD, 2'b11);
    check("rd_valid",   32'(rsp_valid),   1);
    check("rd_data",    32'(rsp_rdata),   32'(e));
    check("rd_err",     32'(rsp_err),     0);
    check("rd_valid_b", 32'(rsp_valid_b), 1);
    check("rd_data_b",  32'(rsp_rdata_b), 32'(e_b));
    check("rd_err_b",   32'(rsp_err_b),   32'(err_b));
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic [1:0] m,
                    input logic [15:0] old, input logic [15:0] old_b, input logic err_b);
    issue(1'b1, a, d, m);
`ifdef DMEM_WRITE_ACK_EN
    check("wack_valid",   32'(rsp_valid),   1);
    check("wack_data",    32'(rsp_rdata),   32'(old));
    check("wack_err",     32'(rsp_err),     0);
    check("wack_valid_b", 32'(rsp_valid_b), 1);
    check("wack_data_b",  32'(rsp_rdata_b), 32'(old_b));
    check("wack_err_b",   32'(rsp_err_b),   32'(err_b));
`else
    check("wr_silent",   32'(rsp_valid),   0);
    check("wr_silent_b", 32'(rsp_valid_b), 0);
`endif
  endtask

  task automatic count_init(input string tag);
    int cnt, cnt_b, ready_bad;
    cnt = 0; cnt_b = 0; ready_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (init_busy) begin
        cnt++;
        if (req_ready) ready_bad++;
      end
      if (init_busy_b) cnt_b++;
      if (!init_busy) break;
      @(negedge clk);
    end
    check({tag, "_cycles"},     32'(cnt),       512);
    check({tag, "_cycles_300"}, 32'(cnt_b),     300);
    check({tag, "_ready_low"},  32'(ready_bad), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h1FF;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(init_busy), 1);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    check("rst_err",   32'(rsp_err),   0);

    // Read of 0x1FF stays queued through INIT and is taken on the first RUN edge.
    reset_n = 1'b1;
    count_init("init");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("first_valid",   32'(rsp_valid),   1);
    check("first_data",    32'(rsp_rdata),   0);
    check("first_err",     32'(rsp_err),     0);
    check("first_err_b",   32'(rsp_err_b),   1);
    check("first_data_b",  32'(rsp_rdata_b), 0);

    wr(9'd5, 16'hBEEF, 2'b11, 16'h0000, 16'h0000, 1'b0);
    rd(9'd5, 16'hBEEF, 16'hBEEF, 1'b0);
    wr(9'd5, 16'h1234, 2'b01, 16'hBEEF, 16'hBEEF, 1'b0);
    rd(9'd5, 16'hBE34, 16'hBE34, 1'b0);
    wr(9'd5, 16'hFFFF, 2'b00, 16'hBE34, 16'hBE34, 1'b0);
    rd(9'd5, 16'hBE34, 16'hBE34, 1'b0);
    wr(9'd7, 16'h7777, 2'b11, 16'h0000, 16'h0000, 1'b0);
    wr(9'd7, 16'hAB00, 2'b10, 16'h7777, 16'h7777, 1'b0);

    // Backpressure: hold response for three cycles with a second read waiting.
    issue(1'b0, 9'd7, 16'h0, 2'b00);
    rsp_ready = 1'b0;
    check("bp_valid", 32'(rsp_valid), 1);
    check("bp_data",  32'(rsp_rdata), 16'hAB77);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'd5;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready_low", 32'(req_ready), 0);
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_data", 32'(rsp_rdata), 16'hAB77);
      check("bp_hold_err", 32'(rsp_err), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_drain", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_next_valid", 32'(rsp_valid), 1);
    check("bp_next_data",  32'(rsp_rdata), 16'hBE34);
    @(posedge clk);
    #1;
    check("bp_drained", 32'(rsp_valid), 0);

    // Out-of-range for the DEPTH=300 instance only.
    rd(9'd400, 16'h0000, 16'h0000, 1'b1);
    wr(9'd400, 16'hAAAA, 2'b11, 16'h0000, 16'h0000, 1'b1);
    rd(9'd400, 16'hAAAA, 16'h0000, 1'b1);
    rd(9'd100, 16'h0000, 16'h0000, 1'b0);
    rd(9'd144, 16'h0000, 16'h0000, 1'b0);
    rd(9'd299, 16'h0000, 16'h0000, 1'b0);
    wr(9'd299, 16'h0F0F, 2'b11, 16'h0000, 16'h0000, 1'b0);
    rd(9'd299, 16'h0F0F, 16'h0F0F, 1'b0);
    wr(9'd5, 16'h5555, 2'b11, 16'hBE34, 16'hBE34, 1'b0);
    rd(9'd5, 16'h5555, 16'h5555, 1'b0);

    // Reset with a held response, then reset again part-way through INIT.
    issue(1'b0, 9'd5, 16'h0, 2'b00);
    rsp_ready = 1'b0;
    check("pre_rst_valid", 32'(rsp_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_rdata", 32'(rsp_rdata), 0);
    check("mid_rst_busy",  32'(init_busy), 1);
    check("mid_rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (100) @(negedge clk);
    check("init100_busy", 32'(init_busy), 1);
    reset_n = 1'b0;
    #1;
    check("init100_rst_busy", 32'(init_busy), 1);
    @(negedge clk);
    reset_n = 1'b1;
    count_init("reinit");
    rd(9'd5,   16'h0000, 16'h0000, 1'b0);
    rd(9'd299, 16'h0000, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
